// File: rtl/canvas_painter.sv
// 32x32 binary canvas painted from mouse samples with a sequential cross brush,
// plus a row-at-a-time clear, a freeze lock and a registered single-pixel read port.
module canvas_painter #(
  parameter int X0          = 144,
  parameter int Y0          = 44,
  parameter int CELL_SHIFT  = 4,
  parameter int BRUSH_CROSS = 1
) (
  input  logic          sysClk,
  input  logic          iRst,
  input  logic [9:0]    iMouseX,
  input  logic [9:0]    iMouseY,
  input  logic          iMouseValid,
  input  logic          iBtnL,
  input  logic          iBtnR,
  input  logic          iClear,
  input  logic          iLock,
  input  logic [4:0]    iRdX,
  input  logic [4:0]    iRdY,
  output logic          oRdPix,
  output logic [1023:0] image,
  output logic          oBusy,
  output logic [10:0]   oInkCnt
);

  localparam logic [10:0] X_LO      = 11'(X0);
  localparam logic [10:0] X_HI      = 11'(X0 + (32 << CELL_SHIFT));
  localparam logic [10:0] Y_LO      = 11'(Y0);
  localparam logic [10:0] Y_HI      = 11'(Y0 + (32 << CELL_SHIFT));
  localparam logic [4:0]  LAST_STEP = (BRUSH_CROSS != 0) ? 5'd4 : 5'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAINT = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      col_q, col_d;
  logic [4:0]      row_q, row_d;
  logic            erase_q, erase_d;
  logic [1023:0]   image_q, image_d;
  logic [10:0]     ink_q, ink_d;
  logic            busy_q, busy_d;
  logic            rd_pix_q, rd_pix_d;

  logic [10:0]     mx, my, dx, dy;
  logic            in_canvas;
  logic [4:0]      hit_col, hit_row;

  logic [4:0]      tgt_col, tgt_row;
  logic            tgt_ok;
  logic [9:0]      tgt_idx;
  logic            tgt_bit;

  // Cursor to cell mapping; dx/dy are only consumed when the range check holds.
  always_comb begin
    mx        = {1'b0, iMouseX};
    my        = {1'b0, iMouseY};
    in_canvas = (mx >= X_LO) && (mx < X_HI) && (my >= Y_LO) && (my < Y_HI);
    dx        = mx - X_LO;
    dy        = my - Y_LO;
    hit_col   = 5'(dx >> CELL_SHIFT);
    hit_row   = 5'(dy >> CELL_SHIFT);
  end

  // Brush step -> target cell; out-of-canvas neighbours are flagged and skipped.
  always_comb begin
    tgt_col = col_q;
    tgt_row = row_q;
    tgt_ok  = 1'b1;
    case (cnt_q)
      5'd1: begin tgt_ok = (col_q != 5'd0);  tgt_col = col_q - 5'd1; end
      5'd2: begin tgt_ok = (col_q != 5'd31); tgt_col = col_q + 5'd1; end
      5'd3: begin tgt_ok = (row_q != 5'd0);  tgt_row = row_q - 5'd1; end
      5'd4: begin tgt_ok = (row_q != 5'd31); tgt_row = row_q + 5'd1; end
      default: ;
    endcase
    tgt_idx = {tgt_row, tgt_col};
    tgt_bit = image_q[tgt_idx];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    erase_d  = erase_q;
    image_d  = image_q;
    ink_d    = ink_q;
    rd_pix_d = image_q[{iRdY, iRdX}];

    case (state_q)
      S_IDLE: begin
        if (!iLock) begin
          if (iClear) begin
            state_d = S_CLEAR;
            cnt_d   = 5'd0;
          end else if (iMouseValid && (iBtnL || iBtnR) && in_canvas) begin
            state_d = S_PAINT;
            cnt_d   = 5'd0;
            col_d   = hit_col;
            row_d   = hit_row;
            erase_d = iBtnR;
          end
        end
      end

      S_PAINT: begin
        if (tgt_ok) begin
          image_d[tgt_idx] = ~erase_q;
          if (!erase_q && !tgt_bit) begin
            ink_d = ink_q + 11'd1;
          end else if (erase_q && tgt_bit) begin
            ink_d = ink_q - 11'd1;
          end
        end
        if (cnt_q == LAST_STEP) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_CLEAR: begin
        image_d[{cnt_q, 5'd0} +: 32] = 32'd0;
        if (cnt_q == 5'd31) begin
          ink_d   = 11'd0;
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sysClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      col_q    <= 5'd0;
      row_q    <= 5'd0;
      erase_q  <= 1'b0;
      image_q  <= '0;
      ink_q    <= 11'd0;
      busy_q   <= 1'b0;
      rd_pix_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      row_q    <= row_d;
      erase_q  <= erase_d;
      image_q  <= image_d;
      ink_q    <= ink_d;
      busy_q   <= busy_d;
      rd_pix_q <= rd_pix_d;
    end
  end

  assign image   = image_q;
  assign oInkCnt = ink_q;
  assign oBusy   = busy_q;
  assign oRdPix  = rd_pix_q;

endmodule

// File: tb/tb_canvas_painter.sv
// Self-checking bench for canvas_painter: directed tables, multi-cycle corner
// sequences and randomized strokes checked against a whole-brush canvas model.
module tb_canvas_painter;

  logic          sysClk = 1'b0;
  logic          iRst = 1'b0;
  logic [9:0]    iMouseX = '0;
  logic [9:0]    iMouseY = '0;
  logic          iMouseValid = 1'b0;
  logic          iBtnL = 1'b0;
  logic          iBtnR = 1'b0;
  logic          iClear = 1'b0;
  logic          iLock = 1'b0;
  logic [4:0]    iRdX = '0;
  logic [4:0]    iRdY = '0;
  logic          oRdPix;
  logic [1023:0] image;
  logic          oBusy;
  logic [10:0]   oInkCnt;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [1023:0] m_img = '0;

  always #5 sysClk = ~sysClk;

  canvas_painter dut (
    .sysClk     (sysClk),
    .iRst       (iRst),
    .iMouseX    (iMouseX),
    .iMouseY    (iMouseY),
    .iMouseValid(iMouseValid),
    .iBtnL      (iBtnL),
    .iBtnR      (iBtnR),
    .iClear     (iClear),
    .iLock      (iLock),
    .iRdX       (iRdX),
    .iRdY       (iRdY),
    .oRdPix     (oRdPix),
    .image      (image),
    .oBusy      (oBusy),
    .oInkCnt    (oInkCnt)
  );

  typedef struct {
    int x;
    int y;
    bit l;
    bit r;
    int cyc;
    int ink;
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int first_diff();
    for (int i = 0; i < 1024; i++) begin
      if (image[i] !== m_img[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk_img(input string name);
    n_cmp++;
    if (image !== m_img) begin
      n_bad++;
      $display("FAIL %s: image popcount %0d expected %0d, first differing bit %0d",
               name, $countones(image), $countones(m_img), first_diff());
    end
  endtask

  function automatic bit accepts(input int x, input int y, input bit l, input bit r);
    return (l || r) && x >= 144 && x < 656 && y >= 44 && y < 556;
  endfunction

  // Whole-brush model: applies the cross in one go with erase winning.
  task automatic model_paint(input int x, input int y, input bit l, input bit r);
    int dc[5];
    int dr[5];
    int c, rw, cc, rr;
    dc = '{0, -1, 1, 0, 0};
    dr = '{0, 0, 0, -1, 1};
    if (!accepts(x, y, l, r)) return;
    c  = (x - 144) / 16;
    rw = (y - 44) / 16;
    for (int k = 0; k < 5; k++) begin
      cc = c + dc[k];
      rr = rw + dr[k];
      if (cc >= 0 && cc < 32 && rr >= 0 && rr < 32) m_img[rr * 32 + cc] = !r;
    end
  endtask

  task automatic strobe(input int x, input int y, input bit l, input bit r);
    iMouseX     = 10'(x);
    iMouseY     = 10'(y);
    iBtnL       = l;
    iBtnR       = r;
    iMouseValid = 1'b1;
    tick();
    iMouseValid = 1'b0;
    iBtnL       = 1'b0;
    iBtnR       = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (oBusy && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic do_paint(input string tag, input int x, input int y,
                          input bit l, input bit r, input int exp_cyc);
    int n;
    model_paint(x, y, l, r);
    strobe(x, y, l, r);
    count_busy(n);
    chk($sformatf("%s_busy", tag), n, exp_cyc);
    chk($sformatf("%s_ink", tag), oInkCnt, $countones(m_img));
    chk_img($sformatf("%s_img", tag));
  endtask

  task automatic do_clear(input string tag);
    int n;
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    count_busy(n);
    m_img = '0;
    chk($sformatf("%s_busy", tag), n, 32);
    chk($sformatf("%s_ink", tag), oInkCnt, 0);
    chk_img($sformatf("%s_img", tag));
  endtask

  initial begin
    int n;
    int exp_bits[5];
    int x, y, rx, ry;
    bit l, r;

    tbl[0]  = '{160, 60, 1'b1, 1'b0, 5, 5};
    tbl[1]  = '{160, 60, 1'b1, 1'b1, 5, 0};
    tbl[2]  = '{160, 60, 1'b0, 1'b1, 5, 0};
    tbl[3]  = '{144, 44, 1'b1, 1'b0, 5, 3};
    tbl[4]  = '{655, 555, 1'b1, 1'b0, 5, 6};
    tbl[5]  = '{656, 555, 1'b1, 1'b0, 0, 6};
    tbl[6]  = '{143, 100, 1'b1, 1'b0, 0, 6};
    tbl[7]  = '{300, 300, 1'b0, 1'b0, 0, 6};
    tbl[8]  = '{300, 555, 1'b1, 1'b0, 5, 10};
    tbl[9]  = '{160, 60, 1'b1, 1'b0, 5, 13};
    tbl[10] = '{400, 43, 1'b0, 1'b1, 0, 13};

    // Reset state
    #1 iRst = 1'b1;
    #1;
    chk("rst_busy", oBusy, 0);
    chk("rst_ink", oInkCnt, 0);
    chk("rst_pix", oRdPix, 0);
    chk_img("rst_img");
    tick();
    tick();
    iRst = 1'b0;
    tick();
    chk("post_rst_busy", oBusy, 0);
    chk("post_rst_ink", oInkCnt, 0);

    // Brush write order for cell (1,1)
    exp_bits = '{33, 32, 34, 1, 65};
    strobe(160, 60, 1'b1, 1'b0);
    chk("order_busy0", oBusy, 1);
    chk("order_pre", $countones(image), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("order_bit%0d", k), image[exp_bits[k]], 1);
      chk($sformatf("order_cnt%0d", k), $countones(image), k + 1);
      chk($sformatf("order_busy%0d", k + 1), oBusy, (k < 4) ? 1 : 0);
    end
    chk("order_ink", oInkCnt, 5);
    model_paint(160, 60, 1'b1, 1'b0);
    chk_img("order_img");

    // Read port latency
    iRdX = 5'd1;
    iRdY = 5'd1;
    tick();
    chk("rd_set", oRdPix, 1);
    iRdX = 5'd5;
    iRdY = 5'd5;
    chk("rd_hold", oRdPix, 1);
    tick();
    chk("rd_clr", oRdPix, 0);

    // Clear with a mouse strobe injected mid-sequence
    do_paint("pre_clr", 400, 400, 1'b1, 1'b0, 5);
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    n = 0;
    while (oBusy && n < 200) begin
      if (n == 10) begin
        iMouseX = 10'd300; iMouseY = 10'd300; iBtnL = 1'b1; iMouseValid = 1'b1;
      end
      tick();
      iMouseValid = 1'b0;
      iBtnL = 1'b0;
      n++;
    end
    m_img = '0;
    chk("clr_busy", n, 32);
    chk("clr_ink", oInkCnt, 0);
    chk_img("clr_img");
    tick();
    chk("clr_after_busy", oBusy, 0);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      do_paint($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].l, tbl[i].r, tbl[i].cyc);
      chk($sformatf("tbl%0d_inkconst", i), oInkCnt, tbl[i].ink);
    end

    // Held iClear restarts immediately after one idle cycle
    iClear = 1'b1;
    tick();
    count_busy(n);
    chk("hold_run1", n, 32);
    tick();
    chk("hold_restart", oBusy, 1);
    iClear = 1'b0;
    count_busy(n);
    chk("hold_run2", n, 32);
    m_img = '0;
    chk_img("hold_img");

    // Lock freezes paint and clear
    do_paint("lock_pre", 300, 300, 1'b1, 1'b0, 5);
    iLock = 1'b1;
    strobe(400, 400, 1'b1, 1'b0);
    chk("lock_paint_busy", oBusy, 0);
    iClear = 1'b1;
    tick();
    tick();
    chk("lock_clr_busy", oBusy, 0);
    iClear = 1'b0;
    tick();
    chk("lock_ink", oInkCnt, $countones(m_img));
    chk_img("lock_img");
    iLock = 1'b0;
    do_clear("unlock_clr");

    // Lock rising mid-paint does not abort the brush
    model_paint(200, 200, 1'b1, 1'b0);
    strobe(200, 200, 1'b1, 1'b0);
    iLock = 1'b1;
    count_busy(n);
    chk("lockmid_busy", n, 5);
    chk("lockmid_ink", oInkCnt, $countones(m_img));
    chk_img("lockmid_img");
    iLock = 1'b0;

    // Randomized strokes against the model
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_clear($sformatf("rnd%0d_clr", i));
      end else begin
        x = int'($urandom_range(100, 700));
        y = int'($urandom_range(0, 600));
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        do_paint($sformatf("rnd%0d", i), x, y, l, r, accepts(x, y, l, r) ? 5 : 0);
      end
      rx = int'($urandom_range(0, 31));
      ry = int'($urandom_range(0, 31));
      iRdX = 5'(rx);
      iRdY = 5'(ry);
      tick();
      chk($sformatf("rnd%0d_pix", i), oRdPix, int'(m_img[ry * 32 + rx]));
    end

    // Asynchronous reset at clear row 10
    do_paint("prerst", 655, 555, 1'b1, 1'b0, 5);
    iRdX = 5'd31;
    iRdY = 5'd31;
    tick();
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    repeat (10) tick();
    chk("mid_clr_busy", oBusy, 1);
    chk("mid_clr_pix", oRdPix, 1);
    iRst = 1'b1;
    #1;
    m_img = '0;
    chk("arst_busy", oBusy, 0);
    chk("arst_ink", oInkCnt, 0);
    chk("arst_pix", oRdPix, 0);
    chk_img("arst_img");
    tick();
    iRst = 1'b0;
    tick();
    chk("arst_idle", oBusy, 0);
    do_paint("after_rst", 160, 60, 1'b1, 1'b0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/canvas_painter.md
Name: canvas_painter

Overview:
Upstream producer of the 32x32 binary user image consumed by the TPU controller and the VGA renderer.
- Converts timed mouse samples (screen coordinates plus buttons) into ink/erase writes on a 1024-bit canvas register, using a sequential cross-shaped brush.
- Provides a multi-cycle clear sequence, a lock input that freezes the canvas while inference runs, and a registered single-pixel read port for the VGA renderer.

Parameters:
- X0, 144, screen x of canvas left edge.
- Y0, 44, screen y of canvas top edge.
- CELL_SHIFT, 4, log2 of screen pixels per canvas cell (16 px cells, 512x512 px canvas).
- BRUSH_CROSS, 1, 1 = centre + 4 neighbours; 0 = centre only.

Ports:
- sysClk  in  1  system clock, all logic on rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iMouseX  in  10  cursor x, screen pixels.
- iMouseY  in  10  cursor y, screen pixels.
- iMouseValid  in  1  one-cycle strobe: new cursor/button sample.
- iBtnL  in  1  left button, ink (write 1).
- iBtnR  in  1  right button, erase (write 0).
- iClear  in  1  clear request, level sampled in IDLE.
- iLock  in  1  freeze canvas; paint and clear ignored while high.
- iRdX  in  5  read-port column.
- iRdY  in  5  read-port row.
- oRdPix  out  1  image[iRdY*32+iRdX], registered, 1-cycle latency.
- image  out  1024  canvas; bit index = row*32 + col; row 0 is top.
- oBusy  out  1  high while in PAINT or CLEAR.
- oInkCnt  out  11  number of set canvas bits, valid when oBusy low.

Behaviour:
Reset (async, iRst=1):
- image=0, oRdPix=0, oBusy=0, oInkCnt=0, FSM=IDLE, step counter=0.
- Reset asserted mid-PAINT or mid-CLEAR aborts immediately to these values.

FSM states: IDLE, PAINT, CLEAR. oBusy = (state != IDLE), registered.

IDLE:
- Priority 1: iLock=1 -> stay IDLE, ignore everything.
- Priority 2: iClear=1 -> CLEAR, row counter=0.
- Priority 3: iMouseValid=1 and (iBtnL or iBtnR) and cursor inside canvas -> latch cell and mode, go to PAINT, step=0.
  - Inside canvas: X0 <= x < X0+(32<<CELL_SHIFT), same rule for y.
  - col = (x-X0)>>CELL_SHIFT, row = (y-Y0)>>CELL_SHIFT. Subtraction is done only after the range check, so there is no wrap.
  - iBtnL and iBtnR both high -> erase wins.
- Otherwise the sample is ignored.

PAINT (one cell per cycle):
- Steps 0..4 = centre, left, right, up, down. BRUSH_CROSS=0 -> step 0 only.
- A neighbour outside 0..31 (e.g. left of col 0) is skipped, but its cycle is still consumed. Fixed length: 5 cycles (1 if BRUSH_CROSS=0).
- Each write updates oInkCnt:
  - ink on a 0 bit -> +1.
  - erase on a 1 bit -> -1.
  - otherwise unchanged.
- Latency: accepted at edge N; cells written at edges N+1..N+5; IDLE at edge N+5.
- iMouseValid during PAINT is dropped (no queue).
- iLock rising during PAINT does not abort; the brush completes.

CLEAR:
- One row (32 bits) zeroed per cycle, rows 0..31; 32 cycles total.
- oInkCnt forced to 0 on the final row write, then IDLE.
- iClear, iLock and mouse samples during CLEAR are ignored.
- iClear still high on return to IDLE starts a new CLEAR.

Read port:
- oRdPix registered every cycle regardless of state and lock.
- Reflects the image contents at the sampling edge.

Test Plan:
- Reset, then strobe (160,60) with iBtnL=1 -> cell (1,1); bits 33,32,34,1,65 set at edges N+1..N+5 in that order; oBusy high 5 cycles; oInkCnt=5.
- Corner strobe (144,44) with iBtnL -> bits 0,1,32 set; skipped steps still consumed (oBusy 5 cycles); oInkCnt=3. Strobe (655,555) -> cell (31,31); (656,555) -> ignored, no change.
- After the first case, strobe (160,60) with iBtnL=1 and iBtnR=1 -> the 5 bits cleared; oInkCnt=0. Repeat the same erase -> oInkCnt stays 0, no underflow.
- Paint two brushes, pulse iClear -> oBusy high exactly 32 cycles; image=0 and oInkCnt=0 when oBusy falls. Strobe mid-CLEAR -> no effect.
- iLock=1, then paint strobe and iClear -> image and oInkCnt unchanged, oBusy stays 0. Drop iLock, pulse iClear -> clear runs.
- Assert iRst at CLEAR row 10 -> all outputs 0 asynchronously; FSM IDLE after release. oRdPix for (1,1) after the first case = 1, one cycle after iRdX/iRdY are applied.
